flash_prog_seq: RTL and testbench

- Flash-ROM bus sequencer for the flasher FPGA.
- Sits downstream of the AVR SPI register file: it receives one latched command (address, data, op) and generates correctly timed 29F040-class bus cycles on the ROM pins (a[18:0], d, csrom, romoe_n, romwe_n).
- Supports JEDEC byte-program, sector-erase and read-array unlock sequences, with DATA# polling and a timeout.
- The AVR no longer has to bit-bang individual bus cycles through the SPI link.

---
 rtl/flash_prog_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_flash_prog_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_prog_seq.sv
// Flash-ROM bus sequencer: turns one latched command into timed 29F040-class
// bus cycles (JEDEC unlock, program, sector erase, read/reset, DATA# polling).
module flash_prog_seq #(
   parameter int unsigned WE_CYC   = 3,
   parameter int unsigned RD_CYC   = 4,
   parameter logic [23:0] POLL_MAX = 24'hFFFFFF
) (
   input  logic        fclk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [1:0]  cmd_op,
   input  logic [18:0] cmd_addr,
   input  logic [7:0]  cmd_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  rd_data,
   output logic [18:0] flash_a,
   output logic [7:0]  flash_dout,
   output logic        flash_doe,
   input  logic [7:0]  flash_din,
   output logic        flash_cs,
   output logic        flash_oe,
   output logic        flash_we
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_RD_ACC, S_GAP
   } state_t;

   typedef enum logic [2:0] {
      PH_WR, PH_POLL, PH_XTRA, PH_RD, PH_RST, PH_END
   } phase_t;

   localparam logic [1:0]  OP_RD    = 2'b00;
   localparam logic [1:0]  OP_PROG  = 2'b01;
   localparam logic [1:0]  OP_RESET = 2'b11;
   localparam logic [18:0] A_555    = 19'h00555;
   localparam logic [18:0] A_2AA    = 19'h002AA;

   state_t      state_q, state_d;
   phase_t      phase_q, phase_d;
   logic [2:0]  step_q, step_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [23:0] poll_cnt_q, poll_cnt_d, poll_inc;
   logic [1:0]  op_q, op_d;
   logic [18:0] caddr_q, caddr_d, addr_q, addr_d, cur_a;
   logic [7:0]  cdata_q, cdata_d, dout_q, dout_d, cur_dat, rd_data_q, rd_data_d;
   logic        cur_rd, exp_dq7;
   logic [2:0]  last_step;
   logic        err_q, err_d, done_q, done_d, busy_q, busy_d;
   logic        cs_q, cs_d, oe_q, oe_d, we_q, we_d, doe_q, doe_d;

   function automatic logic [23:0] sat_inc(input logic [23:0] v);
      return (v == POLL_MAX) ? v : v + 24'd1;
   endfunction

   // Bus operation implied by the current phase/step of the sequence
   always_comb begin
      cur_rd  = 1'b0;
      cur_a   = caddr_q;
      cur_dat = 8'hF0;
      case (phase_q)
         PH_WR: begin
            if (op_q == OP_PROG && step_q == 3'd3) begin
               cur_dat = cdata_q;
            end else begin
               case (step_q)
                  3'd0:    begin cur_a = A_555; cur_dat = 8'hAA; end
                  3'd1:    begin cur_a = A_2AA; cur_dat = 8'h55; end
                  3'd2:    begin cur_a = A_555; cur_dat = (op_q == OP_PROG) ? 8'hA0 : 8'h80; end
                  3'd3:    begin cur_a = A_555; cur_dat = 8'hAA; end
                  3'd4:    begin cur_a = A_2AA; cur_dat = 8'h55; end
                  default: cur_dat = 8'h30;
               endcase
            end
         end
         PH_POLL, PH_XTRA, PH_RD: cur_rd = 1'b1;
         default: ;
      endcase
   end

   assign last_step = (op_q == OP_PROG) ? 3'd3 : 3'd5;
   assign exp_dq7   = (op_q == OP_PROG) ? cdata_q[7] : 1'b1;
   assign poll_inc  = sat_inc(poll_cnt_q);

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      step_d     = step_q;
      cnt_d      = cnt_q;
      poll_cnt_d = poll_cnt_q;
      op_d       = op_q;
      caddr_d    = caddr_q;
      cdata_d    = cdata_q;
      addr_d     = addr_q;
      dout_d     = dout_q;
      rd_data_d  = rd_data_q;
      err_d      = err_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d       = cmd_op;
               caddr_d    = cmd_addr;
               cdata_d    = cmd_data;
               step_d     = 3'd0;
               poll_cnt_d = 24'd0;
               err_d      = 1'b0;
               state_d    = S_START;
               case (cmd_op)
                  OP_RD:    phase_d = PH_RD;
                  OP_RESET: phase_d = PH_RST;
                  default:  phase_d = PH_WR;
               endcase
            end
         end
         S_START, S_GAP: begin
            if (phase_q == PH_END) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else if (cur_rd) begin
               state_d = S_RD_ACC;
               addr_d  = cur_a;
               cnt_d   = 8'd0;
            end else begin
               state_d = S_WR_SETUP;
               addr_d  = cur_a;
               dout_d  = cur_dat;
            end
         end
         S_WR_SETUP: begin
            state_d = S_WR_PULSE;
            cnt_d   = 8'd0;
         end
         S_WR_PULSE: begin
            if (cnt_q == 8'(WE_CYC - 1)) state_d = S_WR_HOLD;
            else                         cnt_d   = cnt_q + 8'd1;
         end
         S_WR_HOLD: begin
            state_d = S_GAP;
            if (phase_q == PH_WR) begin
               if (step_q == last_step) phase_d = PH_POLL;
               else                     step_d  = step_q + 3'd1;
            end else begin
               phase_d = PH_END;
            end
         end
         S_RD_ACC: begin
            if (cnt_q == 8'(RD_CYC - 1)) begin
               state_d = S_GAP;
               if (phase_q == PH_RD) begin
                  rd_data_d = flash_din;
                  phase_d   = PH_END;
               end else if (flash_din[7] == exp_dq7) begin
                  rd_data_d = flash_din;
                  err_d     = 1'b0;
                  phase_d   = PH_END;
               end else if (phase_q == PH_XTRA) begin
                  err_d   = 1'b1;
                  phase_d = PH_RST;
               end else begin
                  poll_cnt_d = poll_inc;
                  if (flash_din[5]) begin
                     phase_d = PH_XTRA;
                  end else if (poll_inc == POLL_MAX) begin
                     err_d   = 1'b1;
                     phase_d = PH_RST;
                  end
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pin strobes are registered from the next state so they never glitch
   always_comb begin
      busy_d = (state_d != S_IDLE);
      we_d   = (state_d == S_WR_PULSE);
      doe_d  = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD);
      oe_d   = (state_d == S_RD_ACC);
      cs_d   = doe_d || oe_d;
   end

   always_ff @(posedge fclk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         phase_q    <= PH_END;
         step_q     <= 3'd0;
         cnt_q      <= 8'd0;
         poll_cnt_q <= 24'd0;
         addr_q     <= 19'd0;
         dout_q     <= 8'd0;
         rd_data_q  <= 8'hFF;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         cs_q       <= 1'b0;
         oe_q       <= 1'b0;
         we_q       <= 1'b0;
         doe_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         step_q     <= step_d;
         cnt_q      <= cnt_d;
         poll_cnt_q <= poll_cnt_d;
         addr_q     <= addr_d;
         dout_q     <= dout_d;
         rd_data_q  <= rd_data_d;
         err_q      <= err_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         cs_q       <= cs_d;
         oe_q       <= oe_d;
         we_q       <= we_d;
         doe_q      <= doe_d;
      end
   end

   always_ff @(posedge fclk) begin
      op_q    <= op_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign rd_data    = rd_data_q;
   assign flash_a    = addr_q;
   assign flash_dout = dout_q;
   assign flash_doe  = doe_q;
   assign flash_cs   = cs_q;
   assign flash_oe   = oe_q;
   assign flash_we   = we_q;

endmodule

// File: tb/tb_flash_prog_seq.sv
// Directed bench for flash_prog_seq: two instances (default and POLL_MAX=5)
// with a small flash model, a bus-cycle logger and protocol assertions.
module tb_flash_prog_seq;

   logic        fclk = 1'b0;
   logic        rst;
   logic [1:0]  cmd_op;
   logic [18:0] cmd_addr;
   logic [7:0]  cmd_data;
   logic        cv [2];
   logic        busy [2], done [2], err [2], fdoe [2], fcs [2], foe [2], fwe [2];
   logic [7:0]  rd_data [2], fdout [2], fdin [2];
   logic [18:0] fa [2];

   int errors = 0;
   int checks = 0;

   // flash model: reads before m_npoll return m_busy, afterwards m_good
   logic [7:0]  m_good [2];
   logic [7:0]  m_busy [2];
   int          m_npoll [2];

   // bus logger
   int          wcount [2]  = '{0, 0};
   int          rdcnt [2]   = '{0, 0};
   int          we_len [2]  = '{0, 0};
   int          oe_len [2]  = '{0, 0};
   int          last_oe_len [2] = '{0, 0};
   logic        we_prev [2] = '{1'b0, 1'b0};
   logic        oe_prev [2] = '{1'b0, 1'b0};
   logic [18:0] rd_a [2]    = '{19'd0, 19'd0};
   logic [18:0] wl_a [2][64];
   logic [7:0]  wl_d [2][64];
   int          wl_len [2][64];
   int          asrt_err = 0;

   always #5 fclk = ~fclk;

   flash_prog_seq dut (
      .fclk(fclk), .rst(rst), .cmd_valid(cv[0]), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
      .cmd_data(cmd_data), .busy(busy[0]), .done(done[0]), .err(err[0]), .rd_data(rd_data[0]),
      .flash_a(fa[0]), .flash_dout(fdout[0]), .flash_doe(fdoe[0]), .flash_din(fdin[0]),
      .flash_cs(fcs[0]), .flash_oe(foe[0]), .flash_we(fwe[0]));

   flash_prog_seq #(.POLL_MAX(24'd5)) dut_to (
      .fclk(fclk), .rst(rst), .cmd_valid(cv[1]), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
      .cmd_data(cmd_data), .busy(busy[1]), .done(done[1]), .err(err[1]), .rd_data(rd_data[1]),
      .flash_a(fa[1]), .flash_dout(fdout[1]), .flash_doe(fdoe[1]), .flash_din(fdin[1]),
      .flash_cs(fcs[1]), .flash_oe(foe[1]), .flash_we(fwe[1]));

   assign fdin[0] = (rdcnt[0] < m_npoll[0]) ? m_busy[0] : m_good[0];
   assign fdin[1] = (rdcnt[1] < m_npoll[1]) ? m_busy[1] : m_good[1];

   always @(negedge fclk) begin
      for (int i = 0; i < 2; i++) begin
         we_prev[i] <= fwe[i];
         oe_prev[i] <= foe[i];
         if (fwe[i]) begin
            we_len[i] <= we_len[i] + 1;
         end else begin
            we_len[i] <= 0;
            if (we_prev[i]) begin
               wl_a[i][wcount[i][5:0]]   <= fa[i];
               wl_d[i][wcount[i][5:0]]   <= fdout[i];
               wl_len[i][wcount[i][5:0]] <= we_len[i];
               wcount[i] <= wcount[i] + 1;
            end
         end
         if (foe[i]) begin
            oe_len[i] <= oe_len[i] + 1;
            rd_a[i]   <= fa[i];
         end else begin
            oe_len[i] <= 0;
            if (oe_prev[i]) begin
               last_oe_len[i] <= oe_len[i];
               rdcnt[i] <= rdcnt[i] + 1;
            end
         end
      end
   end

   always @(negedge fclk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            assert (!(foe[i] && fwe[i])) else begin
               asrt_err <= asrt_err + 1;
               $display("FAIL assert_oe_we[%0d]: oe and we both high at %0t", i, $time);
            end
            assert (!(foe[i] && fdoe[i])) else begin
               asrt_err <= asrt_err + 1;
               $display("FAIL assert_oe_doe[%0d]: oe and doe both high at %0t", i, $time);
            end
            assert (!fwe[i] || (fcs[i] && fdoe[i])) else begin
               asrt_err <= asrt_err + 1;
               $display("FAIL assert_we_cs_doe[%0d]: we without cs/doe at %0t", i, $time);
            end
         end
      end
   end

   // Issue one command at a negedge and wait for done; returns at the done cycle
   task automatic run_cmd(input int i, input logic [1:0] op, input logic [18:0] a,
                          input logic [7:0] d, output int bcyc, output bit ok);
      cmd_op = op; cmd_addr = a; cmd_data = d; cv[i] = 1'b1;
      @(negedge fclk);
      cv[i] = 1'b0;
      bcyc = 0; ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (done[i]) begin ok = 1'b1; break; end
         if (busy[i]) bcyc++;
         @(negedge fclk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge fclk);
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy[0]); end
      checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done[0]); end
      checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err[0]); end
      checks++; if (fcs[0] !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b want 0", fcs[0]); end
      checks++; if (foe[0] !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", foe[0]); end
      checks++; if (fwe[0] !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", fwe[0]); end
      checks++; if (fdoe[0] !== 1'b0) begin errors++; $display("FAIL rst_doe: got %b want 0", fdoe[0]); end
      checks++; if (fa[0] !== 19'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", fa[0]); end
      checks++; if (fdout[0] !== 8'd0) begin errors++; $display("FAIL rst_dout: got %h want 0", fdout[0]); end
      checks++; if (rd_data[0] !== 8'hFF) begin errors++; $display("FAIL rst_rd_data: got %h want ff", rd_data[0]); end
      checks++; if (rd_data[1] !== 8'hFF) begin errors++; $display("FAIL rst_rd_data_to: got %h want ff", rd_data[1]); end
      rst = 1'b0;
      @(negedge fclk);
   endtask

   task automatic test_read;
      int wb, rb, bc; bit ok;
      wb = wcount[0]; rb = rdcnt[0];
      m_good[0] = 8'h5A; m_npoll[0] = rb;
      run_cmd(0, 2'b00, 19'h12345, 8'h00, bc, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL read_done: got %b want 1", ok); end
      checks++; if (bc !== 6) begin errors++; $display("FAIL read_busy_cycles: got %0d want 6", bc); end
      checks++; if (rdcnt[0] - rb !== 1) begin errors++; $display("FAIL read_count: got %0d want 1", rdcnt[0] - rb); end
      checks++; if (last_oe_len[0] !== 4) begin errors++; $display("FAIL read_oe_len: got %0d want 4", last_oe_len[0]); end
      checks++; if (rd_a[0] !== 19'h12345) begin errors++; $display("FAIL read_addr: got %h want 12345", rd_a[0]); end
      checks++; if (rd_data[0] !== 8'h5A) begin errors++; $display("FAIL read_data: got %h want 5a", rd_data[0]); end
      checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL read_err: got %b want 0", err[0]); end
      checks++; if (wcount[0] - wb !== 0) begin errors++; $display("FAIL read_no_writes: got %0d want 0", wcount[0] - wb); end
      @(negedge fclk);
      checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL read_done_width: got %b want 0", done[0]); end
   endtask

   task automatic test_program;
      int wb, rb, bc, idx; bit ok;
      logic [18:0] ea [4];
      logic [7:0]  ed [4];
      ea[0] = 19'h00555; ed[0] = 8'hAA;
      ea[1] = 19'h002AA; ed[1] = 8'h55;
      ea[2] = 19'h00555; ed[2] = 8'hA0;
      ea[3] = 19'h7FFFF; ed[3] = 8'hC3;
      wb = wcount[0]; rb = rdcnt[0];
      m_good[0] = 8'hC3; m_busy[0] = 8'h43; m_npoll[0] = rb + 10;
      run_cmd(0, 2'b01, 19'h7FFFF, 8'hC3, bc, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL prog_done: got %b want 1", ok); end
      checks++; if (wcount[0] - wb !== 4) begin errors++; $display("FAIL prog_writes: got %0d want 4", wcount[0] - wb); end
      for (int k = 0; k < 4; k++) begin
         idx = wb + k;
         checks++; if (wl_a[0][idx[5:0]] !== ea[k]) begin errors++; $display("FAIL prog_wr%0d_addr: got %h want %h", k, wl_a[0][idx[5:0]], ea[k]); end
         checks++; if (wl_d[0][idx[5:0]] !== ed[k]) begin errors++; $display("FAIL prog_wr%0d_data: got %h want %h", k, wl_d[0][idx[5:0]], ed[k]); end
         checks++; if (wl_len[0][idx[5:0]] !== 3) begin errors++; $display("FAIL prog_wr%0d_we_len: got %0d want 3", k, wl_len[0][idx[5:0]]); end
      end
      checks++; if (rdcnt[0] - rb !== 11) begin errors++; $display("FAIL prog_reads: got %0d want 11", rdcnt[0] - rb); end
      checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL prog_err: got %b want 0", err[0]); end
      checks++; if (rd_data[0] !== 8'hC3) begin errors++; $display("FAIL prog_rd_data: got %h want c3", rd_data[0]); end
      @(negedge fclk);
   endtask

   task automatic test_erase;
      int wb, rb, bc, idx; bit ok;
      logic [18:0] ea [6];
      logic [7:0]  ed [6];
      ea[0] = 19'h00555; ed[0] = 8'hAA;
      ea[1] = 19'h002AA; ed[1] = 8'h55;
      ea[2] = 19'h00555; ed[2] = 8'h80;
      ea[3] = 19'h00555; ed[3] = 8'hAA;
      ea[4] = 19'h002AA; ed[4] = 8'h55;
      ea[5] = 19'h10000; ed[5] = 8'h30;
      wb = wcount[0]; rb = rdcnt[0];
      m_good[0] = 8'hFF; m_busy[0] = 8'h00; m_npoll[0] = rb + 3;
      run_cmd(0, 2'b10, 19'h10000, 8'h00, bc, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL erase_done: got %b want 1", ok); end
      checks++; if (wcount[0] - wb !== 6) begin errors++; $display("FAIL erase_writes: got %0d want 6", wcount[0] - wb); end
      for (int k = 0; k < 6; k++) begin
         idx = wb + k;
         checks++; if (wl_a[0][idx[5:0]] !== ea[k]) begin errors++; $display("FAIL erase_wr%0d_addr: got %h want %h", k, wl_a[0][idx[5:0]], ea[k]); end
         checks++; if (wl_d[0][idx[5:0]] !== ed[k]) begin errors++; $display("FAIL erase_wr%0d_data: got %h want %h", k, wl_d[0][idx[5:0]], ed[k]); end
      end
      checks++; if (rdcnt[0] - rb !== 4) begin errors++; $display("FAIL erase_reads: got %0d want 4", rdcnt[0] - rb); end
      checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL erase_err: got %b want 0", err[0]); end
      checks++; if (rd_data[0] !== 8'hFF) begin errors++; $display("FAIL erase_rd_data: got %h want ff", rd_data[0]); end
      @(negedge fclk);
   endtask

   task automatic test_dq5_fail;
      int wb, rb, bc, idx; bit ok;
      wb = wcount[0]; rb = rdcnt[0];
      m_busy[0] = 8'h20; m_npoll[0] = rb + 1000;
      run_cmd(0, 2'b01, 19'h7FFFF, 8'hC3, bc, ok);
      idx = wb + 4;
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL dq5_done: got %b want 1", ok); end
      checks++; if (rdcnt[0] - rb !== 2) begin errors++; $display("FAIL dq5_reads: got %0d want 2", rdcnt[0] - rb); end
      checks++; if (wcount[0] - wb !== 5) begin errors++; $display("FAIL dq5_writes: got %0d want 5", wcount[0] - wb); end
      checks++; if (wl_a[0][idx[5:0]] !== 19'h7FFFF) begin errors++; $display("FAIL dq5_reset_addr: got %h want 7ffff", wl_a[0][idx[5:0]]); end
      checks++; if (wl_d[0][idx[5:0]] !== 8'hF0) begin errors++; $display("FAIL dq5_reset_data: got %h want f0", wl_d[0][idx[5:0]]); end
      checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL dq5_err: got %b want 1", err[0]); end
      @(negedge fclk);
   endtask

   task automatic test_timeout;
      int wb, rb, bc, idx; bit ok;
      wb = wcount[1]; rb = rdcnt[1];
      m_busy[1] = 8'h00; m_good[1] = 8'h80; m_npoll[1] = rb + 1000;
      run_cmd(1, 2'b01, 19'h00ABC, 8'h80, bc, ok);
      idx = wb + 4;
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_done: got %b want 1", ok); end
      checks++; if (rdcnt[1] - rb !== 5) begin errors++; $display("FAIL to_reads: got %0d want 5", rdcnt[1] - rb); end
      checks++; if (wcount[1] - wb !== 5) begin errors++; $display("FAIL to_writes: got %0d want 5", wcount[1] - wb); end
      checks++; if (wl_a[1][idx[5:0]] !== 19'h00ABC) begin errors++; $display("FAIL to_reset_addr: got %h want 00abc", wl_a[1][idx[5:0]]); end
      checks++; if (wl_d[1][idx[5:0]] !== 8'hF0) begin errors++; $display("FAIL to_reset_data: got %h want f0", wl_d[1][idx[5:0]]); end
      checks++; if (err[1] !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", err[1]); end
      @(negedge fclk);
      run_cmd(1, 2'b11, 19'h00ABC, 8'h00, bc, ok);
      checks++; if (bc !== 7) begin errors++; $display("FAIL to_f0_busy_cycles: got %0d want 7", bc); end
      checks++; if (err[1] !== 1'b0) begin errors++; $display("FAIL to_f0_err_clear: got %b want 0", err[1]); end
      @(negedge fclk);
   endtask

   task automatic test_busy_ignore;
      int wb, rb, idx, late; bit ok;
      logic [18:0] ea [4];
      logic [7:0]  ed [4];
      ea[0] = 19'h00555; ed[0] = 8'hAA;
      ea[1] = 19'h002AA; ed[1] = 8'h55;
      ea[2] = 19'h00555; ed[2] = 8'hA0;
      ea[3] = 19'h01234; ed[3] = 8'h96;
      wb = wcount[0]; rb = rdcnt[0];
      m_good[0] = 8'h96; m_npoll[0] = rb;
      cmd_op = 2'b01; cmd_addr = 19'h01234; cmd_data = 8'h96; cv[0] = 1'b1;
      @(negedge fclk); cv[0] = 1'b0;
      repeat (3) @(negedge fclk);
      cmd_op = 2'b00; cmd_addr = 19'h00001; cmd_data = 8'h11; cv[0] = 1'b1;
      @(negedge fclk); cv[0] = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (done[0]) begin ok = 1'b1; break; end
         @(negedge fclk);
      end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ign_done: got %b want 1", ok); end
      checks++; if (wcount[0] - wb !== 4) begin errors++; $display("FAIL ign_writes: got %0d want 4", wcount[0] - wb); end
      for (int k = 0; k < 4; k++) begin
         idx = wb + k;
         checks++; if (wl_a[0][idx[5:0]] !== ea[k] || wl_d[0][idx[5:0]] !== ed[k]) begin
            errors++; $display("FAIL ign_wr%0d: got %h/%h want %h/%h", k, wl_a[0][idx[5:0]], wl_d[0][idx[5:0]], ea[k], ed[k]);
         end
      end
      checks++; if (rdcnt[0] - rb !== 1) begin errors++; $display("FAIL ign_reads: got %0d want 1", rdcnt[0] - rb); end
      checks++; if (rd_data[0] !== 8'h96) begin errors++; $display("FAIL ign_rd_data: got %h want 96", rd_data[0]); end
      late = 0;
      repeat (10) begin @(negedge fclk); if (busy[0]) late++; end
      checks++; if (late !== 0) begin errors++; $display("FAIL ign_not_queued: got %0d busy cycles want 0", late); end
   endtask

   task automatic test_back_to_back;
      int rb, bc; bit ok;
      rb = rdcnt[0];
      m_good[0] = 8'h5A; m_npoll[0] = rb;
      run_cmd(0, 2'b00, 19'h12345, 8'h00, bc, ok);
      checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", done[0]); end
      m_good[0] = 8'h77;
      cmd_addr = 19'h00777; cv[0] = 1'b1;
      @(negedge fclk); cv[0] = 1'b0;
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", busy[0]); end
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (done[0]) begin ok = 1'b1; break; end
         @(negedge fclk);
      end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b want 1", ok); end
      checks++; if (rd_data[0] !== 8'h77) begin errors++; $display("FAIL b2b_rd_data: got %h want 77", rd_data[0]); end
      checks++; if (rd_a[0] !== 19'h00777) begin errors++; $display("FAIL b2b_addr: got %h want 00777", rd_a[0]); end
      checks++; if (rdcnt[0] - rb !== 2) begin errors++; $display("FAIL b2b_reads: got %0d want 2", rdcnt[0] - rb); end
      @(negedge fclk);
   endtask

   task automatic test_reset_mid;
      int wb, bc, idx; bit ok, seen;
      m_good[0] = 8'hC3; m_npoll[0] = rdcnt[0];
      cmd_op = 2'b01; cmd_addr = 19'h7FFFF; cmd_data = 8'hC3; cv[0] = 1'b1;
      @(negedge fclk); cv[0] = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (fwe[0]) begin seen = 1'b1; break; end
         @(negedge fclk);
      end
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rmid_we_seen: got %b want 1", seen); end
      #2 rst = 1'b1;
      #1;
      checks++; if (fwe[0] !== 1'b0) begin errors++; $display("FAIL rmid_we: got %b want 0", fwe[0]); end
      checks++; if (fcs[0] !== 1'b0) begin errors++; $display("FAIL rmid_cs: got %b want 0", fcs[0]); end
      checks++; if (fdoe[0] !== 1'b0) begin errors++; $display("FAIL rmid_doe: got %b want 0", fdoe[0]); end
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy[0]); end
      checks++; if (fa[0] !== 19'd0) begin errors++; $display("FAIL rmid_addr: got %h want 0", fa[0]); end
      @(negedge fclk); rst = 1'b0;
      @(negedge fclk);
      wb = wcount[0];
      run_cmd(0, 2'b11, 19'h7FFFF, 8'h00, bc, ok);
      idx = wb;
      checks++; if (ok !== 1'b1 || bc !== 7) begin errors++; $display("FAIL rmid_f0_seq: got ok=%b busy=%0d want ok=1 busy=7", ok, bc); end
      checks++; if (wcount[0] - wb !== 1) begin errors++; $display("FAIL rmid_f0_writes: got %0d want 1", wcount[0] - wb); end
      checks++; if (wl_a[0][idx[5:0]] !== 19'h7FFFF || wl_d[0][idx[5:0]] !== 8'hF0) begin
         errors++; $display("FAIL rmid_f0_write: got %h/%h want 7ffff/f0", wl_a[0][idx[5:0]], wl_d[0][idx[5:0]]);
      end
      checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b want 0", err[0]); end
      @(negedge fclk);
   endtask

   initial begin
      rst = 1'b1; cv[0] = 1'b0; cv[1] = 1'b0;
      cmd_op = 2'b00; cmd_addr = 19'd0; cmd_data = 8'd0;
      m_good[0] = 8'hFF; m_good[1] = 8'hFF; m_busy[0] = 8'h00; m_busy[1] = 8'h00;
      m_npoll[0] = 0; m_npoll[1] = 0;
      @(negedge fclk);
      test_reset();
      test_read();
      test_program();
      test_erase();
      test_dq5_fail();
      test_timeout();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      checks++; if (asrt_err !== 0) begin errors++; $display("FAIL protocol_assertions: got %0d violations want 0", asrt_err); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
